// File: rtl/wt_cache.sv
// Direct-mapped, write-through, write-allocate cache in front of a 128-bit line memory.
// Read hits answer in the request cycle; misses fill a line and every write goes out as a full-line write.
module wt_cache #(
   parameter int unsigned INDEX_BITS = 3
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         mem_read,
   input  logic         mem_write,
   input  logic [15:0]  mem_address,
   input  logic [15:0]  mem_wdata,
   input  logic [1:0]   mem_byte_enable,
   output logic         mem_resp,
   output logic [15:0]  mem_rdata,
   output logic         pmem_read,
   output logic         pmem_write,
   output logic [15:0]  pmem_address,
   output logic [127:0] pmem_wdata,
   input  logic [127:0] pmem_rdata,
   input  logic         pmem_resp
);

   localparam int unsigned SETS  = 1 << INDEX_BITS;
   localparam int unsigned TAG_W = 12 - INDEX_BITS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_FILL,
      S_WRITE
   } state_e;

   state_e state_q, state_d;

   logic [SETS-1:0]  valid_q, valid_d;
   logic [TAG_W-1:0] tag_q  [SETS];
   logic [127:0]     data_q [SETS];

   logic [INDEX_BITS-1:0] idx;
   logic [TAG_W-1:0]      tag;
   logic [2:0]            word;
   logic [15:0]           line_addr;
   logic [127:0]          line;
   logic [127:0]          merged;
   logic [127:0]          arr_wline;
   logic                  hit;
   logic                  arr_we;
   logic                  fill;

   // Byte address bit 0 never selects anything: words are the smallest unit.
   logic unused_addr_b0;
   assign unused_addr_b0 = mem_address[0];

   assign idx       = mem_address[3+INDEX_BITS:4];
   assign tag       = mem_address[15:4+INDEX_BITS];
   assign word      = mem_address[3:1];
   assign line_addr = {mem_address[15:4], 4'b0000};
   assign line      = data_q[idx];
   assign hit       = valid_q[idx] && (tag_q[idx] == tag);
   assign mem_rdata = line[{word, 4'b0000} +: 16];

   always_comb begin
      merged = line;
      if (mem_byte_enable[0]) merged[{word, 4'b0000} +: 8] = mem_wdata[7:0];
      if (mem_byte_enable[1]) merged[{word, 4'b1000} +: 8] = mem_wdata[15:8];
   end

   always_comb begin
      state_d      = state_q;
      mem_resp     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      pmem_wdata   = '0;
      arr_we       = 1'b0;
      fill         = 1'b0;
      case (state_q)
         S_IDLE: begin
            // Write wins when both strobes are up; a write hit still goes through WRITE.
            if (mem_write) begin
               state_d = hit ? S_WRITE : S_FILL;
            end else if (mem_read) begin
               if (hit) mem_resp = 1'b1;
               else     state_d  = S_FILL;
            end
         end
         S_FILL: begin
            pmem_read    = 1'b1;
            pmem_address = line_addr;
            if (pmem_resp) begin
               arr_we  = 1'b1;
               fill    = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_WRITE: begin
            pmem_write   = 1'b1;
            pmem_address = line_addr;
            pmem_wdata   = merged;
            if (pmem_resp) begin
               arr_we   = 1'b1;
               mem_resp = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign arr_wline = fill ? pmem_rdata : merged;

   always_comb begin
      valid_d = valid_q;
      if (fill) valid_d[idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
      end
   end

   // Tags and data need no reset; arr_we is only possible outside IDLE, which reset forces.
   always_ff @(posedge clk) begin
      if (arr_we) begin
         tag_q[idx]  <= tag;
         data_q[idx] <= arr_wline;
      end
   end

endmodule
